// File: rtl/eruption_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// eruption_scheduler_pkg
//
// Shared definitions for the volcano game round sequencer and the blocks that
// consume its outputs (display, sound):
//   - state_e      : FSM state codes as seen on the 3-bit state output
//   - SCORE_MAX    : score saturation ceiling
//   - sat_add()    : saturating score increment helper
// ---------------------------------------------------------------------------
package eruption_scheduler_pkg;

   // Codes 6 and 7 are never produced; the FSM recovers from them to IDLE.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_RUN   = 3'd2,
      ST_WARN  = 3'd3,
      ST_ERUPT = 3'd4,
      ST_OVER  = 3'd5
   } state_e;

   localparam logic [7:0] SCORE_MAX = 8'd255;

   // Add a small bonus to the score, clamping at SCORE_MAX instead of wrapping.
   function automatic logic [7:0] sat_add(input logic [7:0] base,
                                          input logic [1:0] bonus);
      logic [8:0] sum;
      sum = {1'b0, base} + {7'd0, bonus};
      if (sum > {1'b0, SCORE_MAX}) begin
         return SCORE_MAX;
      end
      return sum[7:0];
   endfunction

endpackage : eruption_scheduler_pkg

// File: rtl/eruption_scheduler_tick_edge_detect.sv
// ---------------------------------------------------------------------------
// tick_edge_detect
//
// Turns each rising edge of the slow game clock clk10 into a single-cycle
// registered pulse in the clk domain.
//
// Ports:
//   clk    in  : system clock
//   resetn in  : asynchronous active-low reset
//   clk10  in  : game clock, already a registered square wave in clk domain
//   tick   out : one-cycle pulse, high the cycle after clk10 rises
// ---------------------------------------------------------------------------
module tick_edge_detect (
   input  logic clk,
   input  logic resetn,
   input  logic clk10,
   output logic tick
);

   logic clk10_d_q;
   logic tick_q;

   // clk10_d resets to 1 so that a clk10 sitting high out of reset does not
   // look like a rising edge; the first tick needs a real 0->1 transition.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         clk10_d_q <= 1'b1;
         tick_q    <= 1'b0;
      end else begin
         clk10_d_q <= clk10;
         tick_q    <= clk10 & ~clk10_d_q;
      end
   end

   assign tick = tick_q;

endmodule : tick_edge_detect

// File: rtl/eruption_scheduler.sv
// ---------------------------------------------------------------------------
// eruption_scheduler
//
// Round sequencer for the volcano game. Counts game ticks through the phases
// IDLE -> ARMED -> RUN -> WARN -> ERUPT -> OVER and keeps a saturating sample
// score. Every output is registered.
//
// Parameters:
//   ROUND_TICKS : ticks in a round before the eruption (2..127)
//   WARN_TICKS  : ticks_left value at which WARN begins (1..ROUND_TICKS-1)
//   ERUPT_TICKS : ticks spent erupting (1..15)
//
// Ports:
//   clk        in  : system clock
//   resetn     in  : asynchronous active-low reset
//   clk10      in  : slow game clock (registered square wave, clk domain)
//   start      in  : level; begins a round from IDLE or OVER
//   sample     in  : one-cycle pulse per collected rock sample
//   abort      in  : return to IDLE, overrides everything else
//   tick       out : one-cycle pulse per clk10 rising edge
//   state      out : FSM state code (see state_e)
//   ticks_left out : remaining round ticks
//   erupt_left out : remaining eruption ticks
//   warning    out : high while in WARN
//   erupting   out : high while in ERUPT
//   score      out : saturating sample score
//   game_over  out : high while in OVER
// ---------------------------------------------------------------------------
module eruption_scheduler
   import eruption_scheduler_pkg::*;
#(
   parameter int unsigned ROUND_TICKS = 60,
   parameter int unsigned WARN_TICKS  = 10,
   parameter int unsigned ERUPT_TICKS = 5
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       clk10,
   input  logic       start,
   input  logic       sample,
   input  logic       abort,
   output logic       tick,
   output logic [2:0] state,
   output logic [6:0] ticks_left,
   output logic [3:0] erupt_left,
   output logic       warning,
   output logic       erupting,
   output logic [7:0] score,
   output logic       game_over
);

   localparam logic [6:0] ROUND_L = 7'(ROUND_TICKS);
   localparam logic [6:0] WARN_L  = 7'(WARN_TICKS);
   localparam logic [3:0] ERUPT_L = 4'(ERUPT_TICKS);

   // ------------------------------------------------------------------
   // Game tick extraction
   // ------------------------------------------------------------------
   logic tick_w;

   tick_edge_detect u_tick_edge_detect (
      .clk    (clk),
      .resetn (resetn),
      .clk10  (clk10),
      .tick   (tick_w)
   );

   assign tick = tick_w;

   // ------------------------------------------------------------------
   // State and counters
   // ------------------------------------------------------------------
   state_e     state_q,      state_d;
   logic [6:0] ticks_left_q, ticks_left_d;
   logic [3:0] erupt_left_q, erupt_left_d;
   logic [7:0] score_q,      score_d;
   logic       warning_q;
   logic       erupting_q;
   logic       game_over_q;

   logic [6:0] ticks_dec;
   logic [3:0] erupt_dec;

   assign ticks_dec = ticks_left_q - 7'd1;
   assign erupt_dec = erupt_left_q - 4'd1;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         ticks_left_q <= 7'd0;
         erupt_left_q <= 4'd0;
         score_q      <= 8'd0;
         warning_q    <= 1'b0;
         erupting_q   <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ticks_left_q <= ticks_left_d;
         erupt_left_q <= erupt_left_d;
         score_q      <= score_d;
         // Flags are decoded from the next state so they switch on the
         // same edge as the state code itself.
         warning_q    <= (state_d == ST_WARN);
         erupting_q   <= (state_d == ST_ERUPT);
         game_over_q  <= (state_d == ST_OVER);
      end
   end

   always_comb begin
      state_d      = state_q;
      ticks_left_d = ticks_left_q;
      erupt_left_d = erupt_left_q;
      score_d      = score_q;

      if (abort) begin
         // Abort freezes counters and score; only the state moves.
         state_d = ST_IDLE;
      end else begin
         // Scoring looks at the state before any transition this cycle, so a
         // sample on the tick that enters WARN still earns the RUN rate.
         if (sample) begin
            if (state_q == ST_RUN) begin
               score_d = sat_add(score_q, 2'd1);
            end else if (state_q == ST_WARN) begin
               score_d = sat_add(score_q, 2'd2);
            end
         end

         case (state_q)
            ST_IDLE, ST_OVER: begin
               if (start) begin
                  state_d      = ST_ARMED;
                  ticks_left_d = ROUND_L;
                  erupt_left_d = 4'd0;
                  score_d      = 8'd0;
               end
            end

            // The tick that leaves ARMED does not count down, so the first
            // countdown step covers a whole game period.
            ST_ARMED: begin
               if (tick_w) begin
                  state_d = ST_RUN;
               end
            end

            ST_RUN: begin
               if (tick_w) begin
                  ticks_left_d = ticks_dec;
                  if (ticks_dec == WARN_L) begin
                     state_d = ST_WARN;
                  end
               end
            end

            ST_WARN: begin
               if (tick_w) begin
                  ticks_left_d = ticks_dec;
                  if (ticks_dec == 7'd0) begin
                     state_d      = ST_ERUPT;
                     erupt_left_d = ERUPT_L;
                  end
               end
            end

            ST_ERUPT: begin
               if (tick_w) begin
                  erupt_left_d = erupt_dec;
                  if (erupt_dec == 4'd0) begin
                     state_d = ST_OVER;
                  end
               end
            end

            // Unused codes fall back to IDLE.
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign state      = state_q;
   assign ticks_left = ticks_left_q;
   assign erupt_left = erupt_left_q;
   assign score      = score_q;
   assign warning    = warning_q;
   assign erupting   = erupting_q;
   assign game_over  = game_over_q;

endmodule : eruption_scheduler
